// File: rtl/uart_peripheral_if.sv
// CPU data-bus slave port for the UART: strobes, address/data in, combinational
// read data and accessibility flags back to the CPU merge logic.
interface uart_peripheral_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        r_accessible;
  logic        w_accessible;

  modport master (output rd, wr, addr, wdata, input rdata, r_accessible, w_accessible);
  modport slave  (input rd, wr, addr, wdata, output rdata, r_accessible, w_accessible);
endinterface

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART: one transmitter, single-byte receive buffer, sticky
// status flags in CON, registered level interrupt.
module uart_peripheral #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic             clk,
  input  logic             reset,
  uart_peripheral_if.slave bus,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic             irqout
);

  localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [30:0] A_TXD   = 31'h4000001C;
  localparam logic [30:0] A_RXD   = 31'h40000020;
  localparam logic [30:0] A_CON   = 31'h40000024;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic [30:0] a;
  logic        hit_txd, hit_rxd, hit_con;
  logic        rx_read, con_wr, tx_accept;
  logic        unused_bits;

  assign a           = bus.addr[30:0];
  assign hit_txd     = (a == A_TXD);
  assign hit_rxd     = (a == A_RXD);
  assign hit_con     = (a == A_CON);
  assign rx_read     = bus.rd & hit_rxd;
  assign con_wr      = bus.wr & hit_con;
  assign unused_bits = ^{bus.addr[31], bus.wdata[31:8]};

  // control / status registers
  logic       tx_irq_en, rx_irq_en, tx_done, rx_valid, rx_overrun, rx_frame_err;
  logic [7:0] txd_reg, rx_data;
  logic       tx_go;

  // ---------------- transmitter ----------------
  uart_state_e tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line, tx_line_n;
  logic        tx_end, tx_wrap, tx_busy;

  assign tx_busy   = (tx_state != S_IDLE);
  // tx_go covers the one cycle between acceptance and the FSM leaving IDLE
  assign tx_accept = bus.wr & hit_txd & ~tx_busy & ~tx_go;
  assign tx_wrap   = (tx_cnt == DIV_M1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_end     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n  = '0;
        tx_line_n = 1'b1;
        if (tx_go) begin
          tx_state_n = S_START;
          tx_line_n  = 1'b0;
          tx_shift_n = txd_reg;
        end
      end
      S_START: if (tx_wrap) begin
        tx_state_n = S_DATA;
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_line_n  = tx_shift[0];
      end
      S_DATA: if (tx_wrap) begin
        tx_cnt_n = '0;
        if (tx_bit == 3'd7) begin
          tx_state_n = S_STOP;
          tx_line_n  = 1'b1;
        end else begin
          tx_bit_n   = tx_bit + 3'd1;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_line_n  = tx_shift[1];
        end
      end
      S_STOP: if (tx_wrap) begin
        tx_state_n = S_IDLE;
        tx_cnt_n   = '0;
        tx_end     = 1'b1;
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  assign uart_tx = tx_line;

  // ---------------- receiver ----------------
  logic        rx_s1, rx_sync;
  uart_state_e rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_ok, rx_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_sync  <= rx_s1;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_ok      = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_sync) rx_state_n = S_START;
      end
      // a start bit that is high again at mid-bit is treated as line noise
      S_START: if (rx_cnt == HALF_M1) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == DIV_M1) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_n = S_STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end
      S_STOP: if (rx_cnt == DIV_M1) begin
        rx_state_n = S_IDLE;
        rx_cnt_n   = '0;
        if (rx_sync) rx_ok  = 1'b1;
        else         rx_bad = 1'b1;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // ---------------- registers and interrupt ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_irq_en    <= 1'b0;
      rx_irq_en    <= 1'b0;
      tx_done      <= 1'b0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      txd_reg      <= '0;
      rx_data      <= '0;
      tx_go        <= 1'b0;
      bus.w_accessible <= 1'b0;
      irqout       <= 1'b0;
    end else begin
      if (con_wr) {rx_irq_en, tx_irq_en} <= bus.wdata[1:0];
      if (tx_accept) txd_reg <= bus.wdata[7:0];
      if (tx_accept)               tx_go <= 1'b1;
      else if (tx_state == S_IDLE) tx_go <= 1'b0;
      // set beats a same-cycle W1C
      if (tx_end)                         tx_done <= 1'b1;
      else if (con_wr && bus.wdata[2])    tx_done <= 1'b0;
      if (rx_ok) rx_data <= rx_shift;
      if (rx_ok)        rx_valid <= 1'b1;
      else if (rx_read) rx_valid <= 1'b0;
      // a byte read in the completing cycle is not lost, so no overrun then
      if (rx_ok && rx_valid && !rx_read) rx_overrun <= 1'b1;
      else if (con_wr && bus.wdata[5])   rx_overrun <= 1'b0;
      if (rx_bad)                        rx_frame_err <= 1'b1;
      else if (con_wr && bus.wdata[6])   rx_frame_err <= 1'b0;
      if (bus.wr) bus.w_accessible <= hit_txd | hit_rxd | hit_con;
      irqout <= (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);
    end
  end

  always_comb begin
    bus.rdata        = 32'hcdcdcdcd;
    bus.r_accessible = 1'b0;
    if (hit_txd) begin
      bus.rdata        = {24'b0, txd_reg};
      bus.r_accessible = 1'b1;
    end else if (hit_rxd) begin
      bus.rdata        = {24'b0, rx_data};
      bus.r_accessible = 1'b1;
    end else if (hit_con) begin
      bus.rdata        = {25'b0, rx_frame_err, rx_overrun, tx_busy, rx_valid,
                          tx_done, rx_irq_en, tx_irq_en};
      bus.r_accessible = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed + randomized bench for uart_peripheral at 16 clocks per bit, with a
// frame-level reference model of the status flags and the serial waveform.
module tb_uart_peripheral;
  localparam int B = 16;
  localparam logic [31:0] A_TXD  = 32'h4000001C;
  localparam logic [31:0] A_RXD  = 32'h40000020;
  localparam logic [31:0] A_CON  = 32'h40000024;
  localparam logic [31:0] A_NONE = 32'h40000028;

  logic clk = 1'b0;
  logic reset, uart_rx, uart_tx, irqout;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic       e_valid, e_ovr, e_ferr, e_done;
  logic [1:0] e_en;
  logic [7:0] e_data;

  uart_peripheral_if bus();

  uart_peripheral #(.BAUD_DIV(B)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irqout(irqout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // returns one time unit after the edge that brings cyc to t
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int n);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.wr = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.rd = 1'b1;
    #1;
    d = bus.rdata;
    @(posedge clk);
    #1;
    bus.rd = 1'b0;
  endtask

  task automatic con_write(input logic [31:0] d);
    int n;
    bus_write(A_CON, d, n);
    e_en = d[1:0];
    if (d[2]) e_done = 1'b0;
    if (d[5]) e_ovr  = 1'b0;
    if (d[6]) e_ferr = 1'b0;
  endtask

  function automatic logic [31:0] exp_con();
    return {25'b0, e_ferr, e_ovr, 1'b0, e_valid, e_done, e_en};
  endfunction

  // serial bit k of a frame: start, 8 data LSB first, stop
  function automatic logic bitv(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic tx_mid(input int n, input logic [7:0] b, input int kfrom);
    for (int k = kfrom; k < 10; k++) begin
      wait_until(n + 1 + k*B + B/2);
      chk($sformatf("tx_mid_bit%0d", k), 32'(uart_tx), 32'(bitv(b, k)));
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    int t0;
    wait_until(cyc + 1);
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      uart_rx = (k == 9) ? stop : bitv(b, k);
      wait_until(t0 + (k+1)*B);
    end
    uart_rx = 1'b1;
    if (stop) begin
      if (e_valid) e_ovr = 1'b1;
      e_valid = 1'b1;
      e_data  = b;
    end else begin
      e_ferr = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b, b2;
    int n, n2;
    e_valid = 0; e_ovr = 0; e_ferr = 0; e_done = 0; e_en = '0; e_data = '0;
    bus.rd = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0;
    uart_rx = 1'b1;
    reset = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 32'(uart_tx), 32'h1);
    chk("reset_irq", 32'(irqout), 32'h0);
    chk("reset_wacc", 32'(bus.w_accessible), 32'h0);
    reset = 1'b1;
    peek(A_CON, d);  chk("reset_con", d, 32'h0);
    peek(A_NONE, d); chk("unmapped_rdata", d, 32'hcdcdcdcd);
    chk("unmapped_racc", 32'(bus.r_accessible), 32'h0);
    peek(A_RXD, d);  chk("rxd_racc", 32'(bus.r_accessible), 32'h1);

    // TX 0xA5 with exact bit timing and tx interrupt
    con_write(32'h1);
    bus_write(A_TXD, 32'hA5, n);
    bus.addr = A_CON;
    for (int k = 0; k < 10; k++) begin
      wait_until(n + 1 + k*B);
      chk($sformatf("tx_a5_start%0d", k), 32'(uart_tx), 32'(bitv(8'hA5, k)));
      if (k == 5) begin
        peek(A_CON, d);
        chk("tx_busy_mid", 32'(d[4]), 32'h1);
      end
      wait_until(n + (k+1)*B);
      chk($sformatf("tx_a5_end%0d", k), 32'(uart_tx), 32'(bitv(8'hA5, k)));
    end
    peek(A_CON, d);
    chk("tx_done_early", 32'(d[2]), 32'h0);
    wait_until(n + 1 + 10*B);
    peek(A_CON, d);
    chk("tx_done_161", 32'(d[2]), 32'h1);
    chk("tx_busy_clear", 32'(d[4]), 32'h0);
    chk("tx_irq_lag", 32'(irqout), 32'h0);
    wait_until(n + 2 + 10*B);
    chk("tx_irq_set", 32'(irqout), 32'h1);
    e_done = 1'b1;
    con_write(32'h5);
    wait_until(cyc + 2);
    chk("tx_irq_w1c", 32'(irqout), 32'h0);
    peek(A_CON, d);  chk("con_after_w1c", d, exp_con());
    peek(A_TXD, d);  chk("txd_readback", d, 32'hA5);

    // random TX byte
    b = 8'($urandom);
    con_write(32'h0);
    bus_write(A_TXD, {24'b0, b}, n);
    tx_mid(n, b, 0);
    wait_until(n + 2 + 10*B);
    e_done = 1'b1;
    peek(A_CON, d);  chk("con_tx_rand", d, exp_con());
    con_write(32'h4);

    // RX 0x3C with rx interrupt
    con_write(32'h2);
    send_frame(8'h3C, 1'b1);
    wait_until(cyc + 2);
    chk("rx_irq_set", 32'(irqout), 32'h1);
    peek(A_CON, d);  chk("con_rx_3c", d, exp_con());
    bus_read(A_RXD, d);
    chk("rxd_3c", d, 32'h3C);
    e_valid = 1'b0;
    wait_until(cyc + 2);
    chk("rx_irq_clear", 32'(irqout), 32'h0);
    peek(A_CON, d);  chk("con_rx_read", d, exp_con());

    // random RX bytes
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      peek(A_CON, d);  chk("con_rx_rand", d, exp_con());
      bus_read(A_RXD, d);
      chk("rxd_rand", d, {24'b0, e_data});
      e_valid = 1'b0;
    end

    // overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    peek(A_RXD, d);  chk("rxd_overrun", d, 32'h22);
    peek(A_CON, d);  chk("con_overrun", d, exp_con());
    con_write(32'h20 | 32'(e_en));
    peek(A_CON, d);  chk("con_ovr_w1c", d, exp_con());

    // framing error leaves the buffered byte and rx_valid alone
    send_frame(8'h77, 1'b0);
    wait_until(cyc + 3*B);
    peek(A_CON, d);  chk("con_frame_err", d, exp_con());
    bus_read(A_RXD, d);
    chk("rxd_after_ferr", d, 32'h22);
    e_valid = 1'b0;
    con_write(32'h40 | 32'(e_en));
    peek(A_CON, d);  chk("con_ferr_w1c", d, exp_con());

    // start-bit glitch
    uart_rx = 1'b0;
    wait_until(cyc + 4);
    uart_rx = 1'b1;
    wait_until(cyc + 3*B);
    peek(A_CON, d);  chk("con_glitch", d, exp_con());

    // TXD write while busy is ignored
    b  = 8'($urandom);
    b2 = ~b;
    bus_write(A_TXD, {24'b0, b}, n);
    wait_until(n + 3*B + 2);
    bus_write(A_TXD, {24'b0, b2}, n2);
    chk("wacc_busy_write", 32'(bus.w_accessible), 32'h1);
    tx_mid(n, b, 4);
    peek(A_TXD, d);  chk("txd_busy_ignored", d, {24'b0, b});
    wait_until(n + 2 + 10*B);
    e_done = 1'b1;
    peek(A_CON, d);  chk("con_busy_frame", d, exp_con());
    bus_write(A_NONE, 32'h0, n2);
    chk("wacc_unmapped", 32'(bus.w_accessible), 32'h0);
    bus_write(A_RXD, 32'h55, n2);
    chk("wacc_rxd", 32'(bus.w_accessible), 32'h1);
    peek(A_RXD, d);  chk("rxd_write_noeffect", d, 32'h22);

    // reset in the middle of a frame of zeros
    con_write(32'h3);
    wait_until(cyc + 2);
    chk("irq_before_reset", 32'(irqout), 32'h1);
    bus_write(A_TXD, 32'h00, n);
    wait_until(n + 40);
    chk("tx_low_before_reset", 32'(uart_tx), 32'h0);
    reset = 1'b0;
    #1;
    chk("reset_mid_tx", 32'(uart_tx), 32'h1);
    chk("reset_mid_irq", 32'(irqout), 32'h0);
    wait_until(cyc + 2);
    reset = 1'b1;
    e_valid = 0; e_ovr = 0; e_ferr = 0; e_done = 0; e_en = '0; e_data = '0;
    peek(A_CON, d);  chk("con_after_reset", d, exp_con());
    peek(A_TXD, d);  chk("txd_after_reset", d, 32'h0);
    peek(A_RXD, d);  chk("rxd_after_reset", d, 32'h0);
    wait_until(cyc + 3*B);
    chk("tx_idle_after_reset", 32'(uart_tx), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_peripheral.md
# uart_peripheral

Memory-mapped 8N1 UART slave on the CPU data bus, alongside the timer/LED/switch/digit peripheral and decoded in the same 0x4000_00xx window. The CPU merges its `rdata`/`r_accessible` with the other slaves. One transmitter and one single-byte receive buffer, with sticky status flags. Drives one level interrupt into the CPU interrupt OR.

## Interface
- `BAUD_DIV`, 5208, clk cycles per bit (50 MHz / 9600); legal range 4..65535; bit counter is 16 bits
- `clk`  in  1  system clock, all state on posedge
- `reset`  in  1  asynchronous, active-low; clears all state
- `rd`  in  1  bus read strobe
- `wr`  in  1  bus write strobe
- `addr`  in  32  byte address; only `addr[30:0]` is decoded
- `wdata`  in  32  write data
- `rdata`  out  32  read data (combinational)
- `r_accessible`  out  1  combinational; 1 when `addr` hits a register of this block
- `w_accessible`  out  1  registered; updated on each edge with `wr`=1 (1 on hit, 0 on miss); holds otherwise; reset 0
- `uart_rx`  in  1  serial input (asynchronous to `clk`)
- `uart_tx`  out  1  serial output; idles high; reset 1
- `irqout`  out  1  level interrupt; reset 0

## Operation
- **Register map** (`addr[30:0]`):
  - `0x4000001C` TXD (W): `wdata[7:0]` starts a frame if `tx_busy`=0; ignored if busy. Reads return `{24'b0, last TXD}`.
  - `0x40000020` RXD (R): `{24'b0, rx_data}`. A read (`rd`=1 at the edge) clears `rx_valid`. Writes are accepted and have no effect.
  - `0x40000024` CON (R/W):
    - Fields: [0] `tx_irq_en`, [1] `rx_irq_en`, [2] `tx_done`, [3] `rx_valid` (RO), [4] `tx_busy` (RO), [5] `rx_overrun`, [6] `rx_frame_err`.
    - Write: loads [1:0]; writing 1 to bit [2], [5] or [6] clears that flag (W1C).
- **Unmapped reads:** `rdata`=`32'hcdcdcdcd`, `r_accessible`=0.
- **Interrupt:** `irqout = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid)`, registered.
- **TX FSM** (IDLE, START, DATA, STOP): 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly `BAUD_DIV` cycles. At the end of STOP: `tx_busy`←0, `tx_done`←1, state IDLE.
- **RX input:** `uart_rx` passes through a 2-flop synchronizer, reset to 1.
- **RX FSM** (IDLE, START, DATA, STOP):
  - IDLE: synchronized rx=0 → START, counter cleared.
  - START: at `BAUD_DIV/2` cycles (integer divide), sample. 1 → glitch, back to IDLE with no flag. 0 → DATA.
  - DATA: sample every `BAUD_DIV` cycles, 8 bits LSB first, then STOP.
  - STOP: sample after `BAUD_DIV` cycles.
    - Stop bit 1: `rx_data`←byte, `rx_valid`←1; if `rx_valid` was already 1, also set `rx_overrun` (old byte lost).
    - Stop bit 0: byte discarded, `rx_frame_err`←1.
    - Either case → IDLE immediately (mid stop bit).
- **Simultaneous events:**
  - RXD read in the same cycle a byte completes: new byte loaded, `rx_valid` stays 1, no overrun.
  - TXD write in the same cycle TX leaves STOP: write ignored (still busy).
  - W1C of `tx_done` in the same cycle it is set: set wins.
- **Reset mid-frame:** both FSMs go to IDLE, `uart_tx`=1, all flags and enables 0, `rx_data`=0, TXD holding register 0.

## Timing
- TXD write accepted at edge N:
  - `tx_busy`=1 and `uart_tx`=0 after edge N+1.
  - Bit k (start = 0) begins at edge N+1+k·`BAUD_DIV`.
  - `tx_done`=1 after edge N+1+10·`BAUD_DIV`.
  - `irqout` follows one edge later.
- RX, for a falling edge on `uart_rx` before edge M:
  - Synchronized edge is seen at M+1.
  - Start sample taken `BAUD_DIV/2` cycles later.
  - `rx_valid` rises ≈ 9.5·`BAUD_DIV`+3 cycles after the line edge (±1 cycle).
- `rdata` and `r_accessible` are combinational from `addr` and current state; RXD read-clear takes effect at the same edge that samples `rd`.
- No back-to-back TX queue: software polls `tx_busy` or uses `tx_done`.

## Test plan
- Reset check, `BAUD_DIV`=16: `uart_tx`=1, `irqout`=0, CON reads `0x00`, address `0x40000028` reads `0xcdcdcdcd` with `r_accessible`=0.
- TX frame, `BAUD_DIV`=16: write `0x4000001C`←`0xA5`.
  - `uart_tx` shows 0,1,0,1,0,0,1,0,1,1, each held 16 cycles.
  - `tx_done`=1 at 161 cycles; with `tx_irq_en`=1, `irqout`=1.
  - W1C of CON bit 2 drops `irqout`.
- RX byte `0x3C` driven at 16 cycles/bit: `rx_valid`=1 and RXD reads `0x3C`; that read clears `rx_valid`; with `rx_irq_en`=1, `irqout` tracks `rx_valid`.
- RX errors:
  - Two bytes `0x11`, `0x22` sent without reading: RXD=`0x22`, `rx_overrun`=1.
  - A frame with stop bit 0: `rx_frame_err`=1, `rx_valid` unchanged.
- Start-bit glitch: 4-cycle low pulse on `uart_rx` → no `rx_valid`, no flags.
- Busy and reset:
  - TXD write during an active frame: frame unaltered, `w_accessible`=1.
  - Assert `reset` mid-frame: `uart_tx`=1 immediately, CON=0 after release.
